// File: rtl/pl_fetch_stage.sv
// pl_fetch_stage -- instruction-fetch (IF) stage of the 5-stage RV32I pipeline.
//
// Holds the fetch PC, presents the instruction-memory word address, and
// registers the IF/ID latch consumed by the decode stage.
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   rstn         in   synchronous reset, ACTIVE-HIGH (1 = reset)
//   stall        in   load-use hazard: hold PC and IF/ID
//   redirect     in   taken branch/jump resolved in EX
//   redirect_pc  in   [XLEN-1:0]    redirect target
//   imem_addr    out  [IMEM_AW-1:0] word address = pc[IMEM_AW+1:2] (combinational)
//   imem_rdata   in   [31:0]        asynchronous-read instruction word
//   pc           out  [XLEN-1:0]    current fetch PC
//   instr        out  [31:0]        imem_rdata pass-through
//   ifid_valid   out  IF/ID holds a real instruction
//   ifid_pc      out  [XLEN-1:0]    PC of instruction in IF/ID
//   ifid_instr   out  [31:0]        instruction in IF/ID (NOP when invalid)
//   ifid_pc4     out  [XLEN-1:0]    ifid_pc + 4
//   misalign_err out  sticky: a redirect target was not word aligned
//   perf_fetch   out  [31:0]        normal-advance count
//   perf_stall   out  [31:0]        stalled-cycle count
//   perf_redir   out  [31:0]        redirect count
//
// Build option: define PL_FETCH_PERF_EN to enable the saturating performance
// counters; otherwise perf_* are tied to zero (ports always present).
//
// Update priority at each posedge: reset > redirect > stall > advance.
// Only imem_rdata -> instr is combinational; stall/redirect reach outputs
// only through registers.

module pl_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [XLEN-1:0]    pc,
  output logic [31:0]        instr,
  output logic               ifid_valid,
  output logic [XLEN-1:0]    ifid_pc,
  output logic [31:0]        ifid_instr,
  output logic [XLEN-1:0]    ifid_pc4,
  output logic               misalign_err,
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_redir
);

  localparam logic [31:0]     NOP  = 32'h0000_0013;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_inc;
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [31:0]     instr_p1;
  logic [XLEN-1:0] pc4_p1;
  logic            misalign_q;

  // pc + 4 wraps modulo 2^XLEN
  assign pc_inc = pc_p0 + FOUR;

  // Upper PC bits are dropped, so out-of-range addresses alias into imem
  assign imem_addr = pc_p0[IMEM_AW+1:2];
  assign instr     = imem_rdata;
  assign pc        = pc_p0;

  // ---- IF (pc_p0) -> IF/ID (_p1) boundary ----
  // The IF/ID contents are reset to a clean bubble because decode observes
  // ifid_pc/ifid_instr directly, not just when valid.
  always_ff @(posedge clk) begin
    if (rstn) begin
      pc_p0      <= RESET_PC;
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      instr_p1   <= NOP;
      pc4_p1     <= '0;
      misalign_q <= 1'b0;
    end else if (redirect) begin
      // Redirect squashes whatever is in IF/ID, including a stalled instruction
      pc_p0    <= {redirect_pc[XLEN-1:2], 2'b00};
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      instr_p1 <= NOP;
      pc4_p1   <= '0;
      if (redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
    end else if (!stall) begin
      pc_p0    <= pc_inc;
      vld_p1   <= 1'b1;
      pc_p1    <= pc_p0;
      instr_p1 <= imem_rdata;
      pc4_p1   <= pc_inc;
    end
  end

  assign ifid_valid   = vld_p1;
  assign ifid_pc      = pc_p1;
  assign ifid_instr   = instr_p1;
  assign ifid_pc4     = pc4_p1;
  assign misalign_err = misalign_q;

`ifdef PL_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] redir_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counters follow the same priority as the PC update, so exactly one
  // of them advances per non-reset cycle.
  always_ff @(posedge clk) begin
    if (rstn) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else if (redirect) begin
      redir_cnt <= sat_inc(redir_cnt);
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else begin
      fetch_cnt <= sat_inc(fetch_cnt);
    end
  end

  assign perf_fetch = fetch_cnt;
  assign perf_stall = stall_cnt;
  assign perf_redir = redir_cnt;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
  assign perf_redir = '0;
`endif

endmodule

// File: tb/tb_pl_fetch_stage.sv
// Directed, table-driven bench for pl_fetch_stage (RESET_PC=0, IMEM_AW=8,
// imem[k] = k+1). Each table row gives the inputs applied before a posedge
// and the state expected just after it.

module tb_pl_fetch_stage;

`ifdef PL_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn, stall, redirect;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc, instr, ifid_pc, ifid_instr, ifid_pc4;
  logic        ifid_valid, misalign_err;
  logic [31:0] perf_fetch, perf_stall, perf_redir;

  logic [31:0] imem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];

  pl_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .IMEM_AW(8)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .misalign_err(misalign_err),
    .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_redir(perf_redir)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        red;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_ipc;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
    logic        e_mis;
    int          e_f;
    int          e_s;
    int          e_r;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_row(input int i);
    logic [31:0] ea;
    logic [31:0] ef, es, er;
    ea = {24'h0, vt[i].e_pc[9:2]};
    ef = PERF ? 32'(vt[i].e_f) : 32'h0;
    es = PERF ? 32'(vt[i].e_s) : 32'h0;
    er = PERF ? 32'(vt[i].e_r) : 32'h0;
    chk("pc",         i, pc,                 vt[i].e_pc);
    chk("imem_addr",  i, {24'h0, imem_addr}, ea);
    chk("instr",      i, instr,              imem[ea[7:0]]);
    chk("ifid_valid", i, {31'h0, ifid_valid}, {31'h0, vt[i].e_v});
    chk("ifid_pc",    i, ifid_pc,            vt[i].e_ipc);
    chk("ifid_instr", i, ifid_instr,         vt[i].e_ins);
    chk("ifid_pc4",   i, ifid_pc4,           vt[i].e_pc4);
    chk("misalign",   i, {31'h0, misalign_err}, {31'h0, vt[i].e_mis});
    chk("perf_fetch", i, perf_fetch, ef);
    chk("perf_stall", i, perf_stall, es);
    chk("perf_redir", i, perf_redir, er);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) imem[k] = 32'(k + 1);

    //            rst  stl  red  rpc            pc             v    ipc            ins      pc4            mis  F  S  R
    vt[0]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h13,  32'h0,        1'b0,0,0,0};
    vt[1]  = '{1'b0,1'b0,1'b0,32'h0,        32'h4,        1'b1,32'h0,        32'h1,   32'h4,        1'b0,1,0,0};
    vt[2]  = '{1'b0,1'b0,1'b0,32'h0,        32'h8,        1'b1,32'h4,        32'h2,   32'h8,        1'b0,2,0,0};
    vt[3]  = '{1'b0,1'b1,1'b0,32'h0,        32'h8,        1'b1,32'h4,        32'h2,   32'h8,        1'b0,2,1,0};
    vt[4]  = '{1'b0,1'b1,1'b0,32'h0,        32'h8,        1'b1,32'h4,        32'h2,   32'h8,        1'b0,2,2,0};
    vt[5]  = '{1'b0,1'b1,1'b0,32'h0,        32'h8,        1'b1,32'h4,        32'h2,   32'h8,        1'b0,2,3,0};
    vt[6]  = '{1'b0,1'b0,1'b0,32'h0,        32'hC,        1'b1,32'h8,        32'h3,   32'hC,        1'b0,3,3,0};
    vt[7]  = '{1'b0,1'b0,1'b0,32'h0,        32'h10,       1'b1,32'hC,        32'h4,   32'h10,       1'b0,4,3,0};
    vt[8]  = '{1'b0,1'b0,1'b1,32'h40,       32'h40,       1'b0,32'h0,        32'h13,  32'h0,        1'b0,4,3,1};
    vt[9]  = '{1'b0,1'b0,1'b0,32'h0,        32'h44,       1'b1,32'h40,       32'h11,  32'h44,       1'b0,5,3,1};
    vt[10] = '{1'b0,1'b1,1'b1,32'h22,       32'h20,       1'b0,32'h0,        32'h13,  32'h0,        1'b1,5,3,2};
    vt[11] = '{1'b0,1'b1,1'b0,32'h0,        32'h20,       1'b0,32'h0,        32'h13,  32'h0,        1'b1,5,4,2};
    vt[12] = '{1'b0,1'b0,1'b0,32'h0,        32'h24,       1'b1,32'h20,       32'h9,   32'h24,       1'b1,6,4,2};
    vt[13] = '{1'b0,1'b0,1'b1,32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0,32'h0,        32'h13,  32'h0,        1'b1,6,4,3};
    vt[14] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'hFFFFFFFC, 32'h100, 32'h0,        1'b1,7,4,3};
    vt[15] = '{1'b0,1'b1,1'b0,32'h0,        32'h0,        1'b1,32'hFFFFFFFC, 32'h100, 32'h0,        1'b1,7,5,3};
    vt[16] = '{1'b0,1'b1,1'b0,32'h0,        32'h0,        1'b1,32'hFFFFFFFC, 32'h100, 32'h0,        1'b1,7,6,3};
    vt[17] = '{1'b0,1'b1,1'b0,32'h0,        32'h0,        1'b1,32'hFFFFFFFC, 32'h100, 32'h0,        1'b1,7,7,3};
    vt[18] = '{1'b1,1'b1,1'b0,32'h0,        32'h0,        1'b0,32'h0,        32'h13,  32'h0,        1'b0,0,0,0};
    vt[19] = '{1'b0,1'b0,1'b0,32'h0,        32'h4,        1'b1,32'h0,        32'h1,   32'h4,        1'b0,1,0,0};
    vt[20] = '{1'b0,1'b0,1'b0,32'h0,        32'h8,        1'b1,32'h4,        32'h2,   32'h8,        1'b0,2,0,0};

    rstn = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rstn = vt[i].rst; stall = vt[i].stl;
      redirect = vt[i].red; redirect_pc = vt[i].rpc;
      @(posedge clk);
      #1;
      check_row(i);
    end

    // Inputs changing mid-cycle must not reach registered outputs.
    // State here: pc=8, ifid {pc=4, instr=2}.
    @(negedge clk);
    rstn = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    #1;
    chk("no_comb_pc",    100, pc,                  32'h8);
    chk("no_comb_valid", 100, {31'h0, ifid_valid}, 32'h1);
    chk("no_comb_ipc",   100, ifid_pc,             32'h4);

    // Reset coincident with redirect and stall: reset wins.
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_redir_pc",  101, pc,                  32'h0);
    chk("rst_over_redir_v",   101, {31'h0, ifid_valid}, 32'h0);
    chk("rst_over_redir_ins", 101, ifid_instr,          32'h13);
    chk("rst_over_redir_mis", 101, {31'h0, misalign_err}, 32'h0);

    // Misaligned redirect with offset 3 then a normal advance from aligned PC.
    @(negedge clk);
    rstn = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h107;
    @(posedge clk);
    #1;
    chk("mis3_pc",  102, pc,                    32'h104);
    chk("mis3_err", 102, {31'h0, misalign_err}, 32'h1);
    @(negedge clk);
    redirect = 1'b0;
    @(posedge clk);
    #1;
    chk("mis3_ipc",  103, ifid_pc,    32'h104);
    chk("mis3_ins",  103, ifid_instr, imem[8'h41]);
    chk("mis3_pc4",  103, ifid_pc4,   32'h108);
    chk("mis3_next", 103, pc,         32'h108);
    chk("mis3_perf_r", 103, perf_redir, PERF ? 32'h1 : 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
